// File: rtl/object_pkg.sv
// Shared types for the projectile object pool: direction/trigger codes, per-slot
// configuration record, pixel clamp and direction-mirror helpers.
package object_pkg;

  typedef enum logic [2:0] {
    DIR_U  = 3'd0,
    DIR_UR = 3'd1,
    DIR_R  = 3'd2,
    DIR_DR = 3'd3,
    DIR_D  = 3'd4,
    DIR_DL = 3'd5,
    DIR_L  = 3'd6,
    DIR_UL = 3'd7
  } dir_t;

  typedef enum logic [1:0] {
    TRIG_NONE     = 2'd0,
    TRIG_BOX      = 2'd1,
    TRIG_SCREEN   = 2'd2,
    TRIG_NONE_ALT = 2'd3
  } trig_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef struct packed {
    dir_t        dir;
    trig_t       trig;
    logic [9:0]  w;
    logic [9:0]  h;
    logic [9:0]  box_x1;
    logic [9:0]  box_y1;
    logic [9:0]  box_x2;
    logic [9:0]  box_y2;
    logic [7:0]  life;
  } slot_cfg_t;

  // px is the already floor-shifted integer position
  function automatic logic [9:0] clamp_px(input logic signed [15:0] px);
    if (px < 16'sd0) begin
      return 10'd0;
    end else if (px > 16'sd1023) begin
      return 10'd1023;
    end else begin
      return px[9:0];
    end
  endfunction

  // Negate the horizontal component: d -> (8 - d) mod 8
  function automatic dir_t mirror_h(input dir_t d);
    return dir_t'(3'd0 - 3'(d));
  endfunction

  // Negate the vertical component: d -> (4 - d) mod 8
  function automatic dir_t mirror_v(input dir_t d);
    return dir_t'(3'd4 - 3'(d));
  endfunction

endpackage

// File: rtl/object_slot.sv
// One projectile slot: fixed-point position accumulators, lifetime counters and
// bounds checking. Define OBJECT_BOUNCE_EN to make box-triggered slots reflect.
module object_slot
  import object_pkg::*;
#(
  parameter int FRAC_BITS  = 3,
  parameter int SPEED_W    = 5,
  parameter int CS_PER_SEC = 100
) (
  input  logic               clk_centi_second,
  input  logic               reset,
  input  logic               load,
  input  logic               kill,
  input  logic [2:0]         spawn_dir,
  input  logic [9:0]         spawn_x,
  input  logic [9:0]         spawn_y,
  input  logic [9:0]         spawn_w,
  input  logic [9:0]         spawn_h,
  input  logic [SPEED_W-1:0] spawn_speed,
  input  logic [7:0]         spawn_life,
  input  logic [1:0]         spawn_trigger,
  input  logic [9:0]         display_x1,
  input  logic [9:0]         display_y1,
  input  logic [9:0]         display_x2,
  input  logic [9:0]         display_y2,
  output logic               active,
  output logic [9:0]         pos_x,
  output logic [9:0]         pos_y,
  output logic [9:0]         size_w,
  output logic [9:0]         size_h
);

  localparam int POS_W = 10 + FRAC_BITS + 2;
  localparam int CMP_W = POS_W + 2;
  localparam int SUB_W = (CS_PER_SEC > 1) ? $clog2(CS_PER_SEC) : 1;

  logic                    active_r;
  slot_cfg_t               cfg_r;
  logic signed [POS_W-1:0] x_r, y_r;
  logic [SPEED_W-1:0]      speed_r;
  logic [SUB_W-1:0]        sub_r;

  logic signed [POS_W-1:0] x_mv_s, y_mv_s, x_nx_s, y_nx_s;
  logic signed [CMP_W-1:0] xe_s, ye_s, lo_x_s, hi_x_s, lo_y_s, hi_y_s;
  logic                    check_en_s, out_s, bounds_hit_s, wrap_s, retire_s;
  dir_t                    dir_nx_s;
  logic [SUB_W-1:0]        sub_nx_s;
  logic [7:0]              life_nx_s;

  // Saturating step so a long-lived untriggered slot never wraps around
  function automatic logic signed [POS_W-1:0] step_sat(input logic signed [POS_W-1:0] p,
                                                       input logic [SPEED_W-1:0] spd,
                                                       input logic neg);
    logic [POS_W:0] sum;
    logic [POS_W:0] d;
    d = {{(POS_W + 1 - SPEED_W){1'b0}}, spd};
    if (neg) begin
      sum = {p[POS_W-1], p} - d;
    end else begin
      sum = {p[POS_W-1], p} + d;
    end
    if (sum[POS_W] != sum[POS_W-1]) begin
      return sum[POS_W] ? {1'b1, {(POS_W-1){1'b0}}} : {1'b0, {(POS_W-1){1'b1}}};
    end else begin
      return sum[POS_W-1:0];
    end
  endfunction

  function automatic logic signed [CMP_W-1:0] to_fx(input logic [9:0] v);
    return $signed(CMP_W'({v, {FRAC_BITS{1'b0}}}));
  endfunction

  // Motion step, bounds/bounce evaluation and lifetime countdown
  always_comb begin
    x_mv_s = x_r;
    y_mv_s = y_r;
    case (cfg_r.dir)
      DIR_UR, DIR_R, DIR_DR: x_mv_s = step_sat(x_r, speed_r, 1'b0);
      DIR_DL, DIR_L, DIR_UL: x_mv_s = step_sat(x_r, speed_r, 1'b1);
      default:               x_mv_s = x_r;
    endcase
    case (cfg_r.dir)
      DIR_DR, DIR_D, DIR_DL: y_mv_s = step_sat(y_r, speed_r, 1'b0);
      DIR_U, DIR_UR, DIR_UL: y_mv_s = step_sat(y_r, speed_r, 1'b1);
      default:               y_mv_s = y_r;
    endcase

    xe_s = CMP_W'(x_mv_s);
    ye_s = CMP_W'(y_mv_s);
    case (cfg_r.trig)
      TRIG_SCREEN: begin
        check_en_s = 1'b1;
        lo_x_s = '0;
        lo_y_s = '0;
        hi_x_s = to_fx(10'(SCREEN_W));
        hi_y_s = to_fx(10'(SCREEN_H));
      end
      TRIG_BOX: begin
        check_en_s = 1'b1;
        lo_x_s = to_fx(cfg_r.box_x1);
        lo_y_s = to_fx(cfg_r.box_y1);
        hi_x_s = to_fx(cfg_r.box_x2);
        hi_y_s = to_fx(cfg_r.box_y2);
      end
      default: begin
        check_en_s = 1'b0;
        lo_x_s = '0;
        lo_y_s = '0;
        hi_x_s = '0;
        hi_y_s = '0;
      end
    endcase
    // Retire only once the whole object has left through the low edge
    out_s = (xe_s > hi_x_s) || (ye_s > hi_y_s) ||
            ((xe_s + to_fx(cfg_r.w)) < lo_x_s) || ((ye_s + to_fx(cfg_r.h)) < lo_y_s);

    x_nx_s       = x_mv_s;
    y_nx_s       = y_mv_s;
    dir_nx_s     = cfg_r.dir;
    bounds_hit_s = check_en_s & out_s;
`ifdef OBJECT_BOUNCE_EN
    // Box slots reflect off the box edges (top-left corner kept inside)
    if (cfg_r.trig == TRIG_BOX) begin
      bounds_hit_s = 1'b0;
      if (xe_s > hi_x_s) begin
        x_nx_s   = POS_W'(hi_x_s);
        dir_nx_s = mirror_h(dir_nx_s);
      end else if (xe_s < lo_x_s) begin
        x_nx_s   = POS_W'(lo_x_s);
        dir_nx_s = mirror_h(dir_nx_s);
      end else begin
        x_nx_s = x_mv_s;
      end
      if (ye_s > hi_y_s) begin
        y_nx_s   = POS_W'(hi_y_s);
        dir_nx_s = mirror_v(dir_nx_s);
      end else if (ye_s < lo_y_s) begin
        y_nx_s   = POS_W'(lo_y_s);
        dir_nx_s = mirror_v(dir_nx_s);
      end else begin
        y_nx_s = y_mv_s;
      end
    end else begin
      bounds_hit_s = check_en_s & out_s;
    end
`endif

    wrap_s    = (sub_r == SUB_W'(CS_PER_SEC - 1));
    sub_nx_s  = wrap_s ? '0 : sub_r + SUB_W'(1);
    life_nx_s = (wrap_s && (cfg_r.life != 8'd0)) ? cfg_r.life - 8'd1 : cfg_r.life;
    retire_s  = (wrap_s && (cfg_r.life == 8'd1)) || bounds_hit_s;
  end

  // Slot state: reset > kill > spawn load > motion of an active slot
  always_ff @(posedge clk_centi_second) begin
    if (reset) begin
      active_r <= 1'b0;
      cfg_r    <= '0;
      x_r      <= '0;
      y_r      <= '0;
      speed_r  <= '0;
      sub_r    <= '0;
    end else if (kill) begin
      active_r <= 1'b0;
    end else if (load) begin
      active_r     <= 1'b1;
      cfg_r.dir    <= dir_t'(spawn_dir);
      cfg_r.trig   <= trig_t'(spawn_trigger);
      cfg_r.w      <= spawn_w;
      cfg_r.h      <= spawn_h;
      cfg_r.box_x1 <= display_x1;
      cfg_r.box_y1 <= display_y1;
      cfg_r.box_x2 <= display_x2;
      cfg_r.box_y2 <= display_y2;
      cfg_r.life   <= spawn_life;
      x_r          <= $signed(POS_W'({spawn_x, {FRAC_BITS{1'b0}}}));
      y_r          <= $signed(POS_W'({spawn_y, {FRAC_BITS{1'b0}}}));
      speed_r      <= spawn_speed;
      sub_r        <= '0;
    end else if (active_r) begin
      active_r   <= ~retire_s;
      x_r        <= x_nx_s;
      y_r        <= y_nx_s;
      cfg_r.dir  <= dir_nx_s;
      cfg_r.life <= life_nx_s;
      sub_r      <= sub_nx_s;
    end
  end

  // Renderer view: integer pixels, zeroed while the slot is free
  always_comb begin
    active = active_r;
    if (active_r) begin
      pos_x  = clamp_px(16'(x_r >>> FRAC_BITS));
      pos_y  = clamp_px(16'(y_r >>> FRAC_BITS));
      size_w = cfg_r.w;
      size_h = cfg_r.h;
    end else begin
      pos_x  = 10'd0;
      pos_y  = 10'd0;
      size_w = 10'd0;
      size_h = 10'd0;
    end
  end

endmodule

// File: rtl/object_pool_motion_controller.sv
// Projectile pool: lowest-free slot allocation, kill_all fan-out and flattened
// renderer buses. OBJECT_BOUNCE_EN (see object_slot) enables box reflection.
module object_pool_motion_controller
  import object_pkg::*;
#(
  parameter  int NUM_OBJ    = 8,
  parameter  int FRAC_BITS  = 3,
  parameter  int SPEED_W    = 5,
  parameter  int CS_PER_SEC = 100,
  localparam int IDX_W      = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                  clk_centi_second,
  input  logic                  reset,
  input  logic                  spawn_valid,
  output logic                  spawn_ready,
  input  logic [2:0]            spawn_dir,
  input  logic [9:0]            spawn_x,
  input  logic [9:0]            spawn_y,
  input  logic [9:0]            spawn_w,
  input  logic [9:0]            spawn_h,
  input  logic [SPEED_W-1:0]    spawn_speed,
  input  logic [7:0]            spawn_life,
  input  logic [1:0]            spawn_trigger,
  input  logic [9:0]            display_x1,
  input  logic [9:0]            display_y1,
  input  logic [9:0]            display_x2,
  input  logic [9:0]            display_y2,
  input  logic                  kill_all,
  output logic                  spawn_ack,
  output logic [IDX_W-1:0]      spawn_slot,
  output logic [NUM_OBJ-1:0]    obj_active,
  output logic [NUM_OBJ*10-1:0] obj_pos_x,
  output logic [NUM_OBJ*10-1:0] obj_pos_y,
  output logic [NUM_OBJ*10-1:0] obj_w,
  output logic [NUM_OBJ*10-1:0] obj_h
);

  logic [IDX_W-1:0]   free_idx_s;
  logic               free_found_s;
  logic               accept_s;
  logic [NUM_OBJ-1:0] load_s;

  // Lowest-index free slot; scanning downward lets the lowest index win
  always_comb begin
    free_idx_s   = '0;
    free_found_s = 1'b0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (!obj_active[i]) begin
        free_idx_s   = IDX_W'(i);
        free_found_s = 1'b1;
      end else begin
        free_idx_s   = free_idx_s;
      end
    end
  end

  assign spawn_ready = free_found_s & ~kill_all;
  assign accept_s    = spawn_valid & spawn_ready;

  // One-hot load strobe to the chosen slot
  always_comb begin
    load_s = '0;
    if (accept_s) begin
      load_s[free_idx_s] = 1'b1;
    end else begin
      load_s = '0;
    end
  end

  // Acknowledge pulse and the slot it landed in
  always_ff @(posedge clk_centi_second) begin
    if (reset) begin
      spawn_ack  <= 1'b0;
      spawn_slot <= '0;
    end else begin
      spawn_ack <= accept_s;
      if (accept_s) begin
        spawn_slot <= free_idx_s;
      end
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_slot
    object_slot #(
      .FRAC_BITS  (FRAC_BITS),
      .SPEED_W    (SPEED_W),
      .CS_PER_SEC (CS_PER_SEC)
    ) u_slot (
      .clk_centi_second (clk_centi_second),
      .reset            (reset),
      .load             (load_s[g]),
      .kill             (kill_all),
      .spawn_dir        (spawn_dir),
      .spawn_x          (spawn_x),
      .spawn_y          (spawn_y),
      .spawn_w          (spawn_w),
      .spawn_h          (spawn_h),
      .spawn_speed      (spawn_speed),
      .spawn_life       (spawn_life),
      .spawn_trigger    (spawn_trigger),
      .display_x1       (display_x1),
      .display_y1       (display_y1),
      .display_x2       (display_x2),
      .display_y2       (display_y2),
      .active           (obj_active[g]),
      .pos_x            (obj_pos_x[10*g +: 10]),
      .pos_y            (obj_pos_y[10*g +: 10]),
      .size_w           (obj_w[10*g +: 10]),
      .size_h           (obj_h[10*g +: 10])
    );
  end

endmodule

// File: tb/tb_object_pool_motion_controller.sv
// Scoreboard bench for object_pool_motion_controller: stimulus queues expected
// values, a negedge monitor compares them against the DUT outputs.
module tb_object_pool_motion_controller;

  localparam int N = 8;
  localparam int K_ACT = 0, K_PX = 1, K_PY = 2, K_RDY = 3, K_DRAIN = 4;

  logic          clk_centi_second = 1'b0;
  logic          reset = 1'b1;
  logic          spawn_valid = 1'b0;
  logic          spawn_ready;
  logic [2:0]    spawn_dir = 3'd0;
  logic [9:0]    spawn_x = 10'd0, spawn_y = 10'd0, spawn_w = 10'd0, spawn_h = 10'd0;
  logic [4:0]    spawn_speed = 5'd0;
  logic [7:0]    spawn_life = 8'd0;
  logic [1:0]    spawn_trigger = 2'd0;
  logic [9:0]    display_x1 = 10'd100, display_y1 = 10'd100;
  logic [9:0]    display_x2 = 10'd200, display_y2 = 10'd200;
  logic          kill_all = 1'b0;
  logic          spawn_ack;
  logic [2:0]    spawn_slot;
  logic [N-1:0]  obj_active;
  logic [N*10-1:0] obj_pos_x, obj_pos_y, obj_w, obj_h;

  typedef struct {
    int kind;
    int idx;
    int exp;
  } chk_t;

  chk_t chk_q[$];
  int   ack_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  object_pool_motion_controller dut (
    .clk_centi_second (clk_centi_second),
    .reset            (reset),
    .spawn_valid      (spawn_valid),
    .spawn_ready      (spawn_ready),
    .spawn_dir        (spawn_dir),
    .spawn_x          (spawn_x),
    .spawn_y          (spawn_y),
    .spawn_w          (spawn_w),
    .spawn_h          (spawn_h),
    .spawn_speed      (spawn_speed),
    .spawn_life       (spawn_life),
    .spawn_trigger    (spawn_trigger),
    .display_x1       (display_x1),
    .display_y1       (display_y1),
    .display_x2       (display_x2),
    .display_y2       (display_y2),
    .kill_all         (kill_all),
    .spawn_ack        (spawn_ack),
    .spawn_slot       (spawn_slot),
    .obj_active       (obj_active),
    .obj_pos_x        (obj_pos_x),
    .obj_pos_y        (obj_pos_y),
    .obj_w            (obj_w),
    .obj_h            (obj_h)
  );

  always #5 clk_centi_second = ~clk_centi_second;

  function automatic string kname(input int k);
    case (k)
      K_ACT:   return "obj_active";
      K_PX:    return "obj_pos_x";
      K_PY:    return "obj_pos_y";
      K_RDY:   return "spawn_ready";
      K_DRAIN: return "acks_missing";
      default: return "unknown";
    endcase
  endfunction

  function automatic int sample(input int kind, input int idx);
    case (kind)
      K_ACT:   return int'(obj_active);
      K_PX:    return int'(obj_pos_x[10*idx +: 10]);
      K_PY:    return int'(obj_pos_y[10*idx +: 10]);
      K_RDY:   return int'(spawn_ready);
      K_DRAIN: return ack_q.size();
      default: return -1;
    endcase
  endfunction

  // Monitor: compare acks against the ack queue and drain queued state checks
  always @(negedge clk_centi_second) begin : monitor
    chk_t c;
    int   act;
    int   e;
    if (spawn_ack) begin
      n_chk++;
      if (ack_q.size() == 0) begin
        n_err++;
        $display("FAIL spawn_ack: got ack for slot %0d, required no ack", spawn_slot);
      end else begin
        e = ack_q.pop_front();
        if (int'(spawn_slot) != e) begin
          n_err++;
          $display("FAIL spawn_slot: got %0d, required %0d", spawn_slot, e);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      act = sample(c.kind, c.idx);
      n_chk++;
      if (act != c.exp) begin
        n_err++;
        $display("FAIL %s[%0d] at %0t: got %0d (0x%0h), required %0d (0x%0h)",
                 kname(c.kind), c.idx, $time, act, act, c.exp, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk_centi_second);
    #1;
  endtask

  task automatic expect_val(input int kind, input int idx, input int exp);
    chk_t c;
    c.kind = kind;
    c.idx  = idx;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic set_spawn(input int x, input int y, input int dir, input int speed,
                           input int life, input int trig, input int w, input int h);
    spawn_x       = 10'(x);
    spawn_y       = 10'(y);
    spawn_dir     = 3'(dir);
    spawn_speed   = 5'(speed);
    spawn_life    = 8'(life);
    spawn_trigger = 2'(trig);
    spawn_w       = 10'(w);
    spawn_h       = 10'(h);
  endtask

  task automatic kill_pool();
    kill_all = 1'b1;
    tick();
    kill_all = 1'b0;
    expect_val(K_ACT, 0, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    expect_val(K_ACT, 0, 0);
    expect_val(K_PX, 0, 0);
    expect_val(K_RDY, 0, 1);

    // T1: rightward motion, 1 px per edge
    set_spawn(100, 200, 2, 8, 0, 0, 16, 16);
    spawn_valid = 1'b1;
    ack_q.push_back(0);
    tick();
    spawn_valid = 1'b0;
    expect_val(K_ACT, 0, 1);
    expect_val(K_PX, 0, 100);
    expect_val(K_PY, 0, 200);
    tick();
    expect_val(K_PX, 0, 101);
    tick();
    expect_val(K_PX, 0, 102);
    expect_val(K_PY, 0, 200);
    kill_pool();

    // T2: life 2 -> active exactly 200 edges, slot reused
    set_spawn(50, 60, 0, 0, 2, 0, 4, 4);
    spawn_valid = 1'b1;
    ack_q.push_back(0);
    tick();
    spawn_valid = 1'b0;
    expect_val(K_ACT, 0, 1);
    repeat (199) tick();
    expect_val(K_ACT, 0, 1);
    tick();
    expect_val(K_ACT, 0, 0);
    expect_val(K_PX, 0, 0);
    set_spawn(7, 60, 0, 0, 0, 0, 4, 4);
    spawn_valid = 1'b1;
    ack_q.push_back(0);
    tick();
    spawn_valid = 1'b0;
    expect_val(K_PX, 0, 7);
    kill_pool();

    // T3: fill pool, 9th request held until slot 3 expires
    spawn_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_spawn(10 * i, 20, 0, 0, (i == 3) ? 1 : 0, 0, 4, 4);
      ack_q.push_back(i);
      tick();
    end
    set_spawn(500, 20, 0, 0, 0, 0, 4, 4);
    expect_val(K_ACT, 0, 8'hff);
    expect_val(K_RDY, 0, 0);
    repeat (95) tick();
    expect_val(K_ACT, 0, 8'hff);
    tick();
    expect_val(K_ACT, 0, 8'hf7);
    expect_val(K_RDY, 0, 1);
    ack_q.push_back(3);
    tick();
    spawn_valid = 1'b0;
    expect_val(K_ACT, 0, 8'hff);
    expect_val(K_PX, 3, 500);
    kill_pool();

    // T4a: screen trigger, right edge exit at x>640
    set_spawn(635, 100, 2, 16, 0, 2, 4, 4);
    spawn_valid = 1'b1;
    ack_q.push_back(0);
    tick();
    spawn_valid = 1'b0;
    expect_val(K_PX, 0, 635);
    tick();
    tick();
    expect_val(K_ACT, 0, 1);
    expect_val(K_PX, 0, 639);
    tick();
    expect_val(K_ACT, 0, 0);

    // T4b: screen trigger, left exit only when x+w<0 (signed)
    set_spawn(2, 100, 6, 8, 0, 2, 4, 4);
    spawn_valid = 1'b1;
    ack_q.push_back(0);
    tick();
    spawn_valid = 1'b0;
    expect_val(K_PX, 0, 2);
    repeat (6) tick();
    expect_val(K_ACT, 0, 1);
    expect_val(K_PX, 0, 0);
    tick();
    expect_val(K_ACT, 0, 0);

    // T5: kill_all beats a simultaneous spawn
    set_spawn(300, 300, 0, 0, 0, 0, 4, 4);
    spawn_valid = 1'b1;
    ack_q.push_back(0);
    tick();
    kill_all = 1'b1;
    expect_val(K_RDY, 0, 0);
    tick();
    kill_all = 1'b0;
    expect_val(K_ACT, 0, 0);
    expect_val(K_RDY, 0, 1);
    ack_q.push_back(0);
    tick();
    spawn_valid = 1'b0;
    expect_val(K_ACT, 0, 1);
    expect_val(K_PX, 0, 300);
    kill_pool();

    // T6: box trigger, right edge of box 100..200
    set_spawn(195, 120, 3, 24, 0, 1, 4, 4);
    spawn_valid = 1'b1;
    ack_q.push_back(0);
    tick();
    spawn_valid = 1'b0;
    expect_val(K_PX, 0, 195);
    tick();
    expect_val(K_PX, 0, 198);
    tick();
`ifdef OBJECT_BOUNCE_EN
    expect_val(K_ACT, 0, 1);
    expect_val(K_PX, 0, 200);
    expect_val(K_PY, 0, 126);
    tick();
    expect_val(K_PX, 0, 197);
    expect_val(K_PY, 0, 129);
    kill_pool();
`else
    expect_val(K_ACT, 0, 0);
    expect_val(K_PX, 0, 0);
`endif

    // T7: reset mid-operation overrides spawn and kill_all
    set_spawn(400, 400, 2, 8, 0, 0, 4, 4);
    spawn_valid = 1'b1;
    ack_q.push_back(0);
    tick();
    kill_all = 1'b1;
    reset    = 1'b1;
    tick();
    expect_val(K_ACT, 0, 0);
    expect_val(K_PX, 0, 0);
    reset       = 1'b0;
    kill_all    = 1'b0;
    spawn_valid = 1'b0;
    tick();
    expect_val(K_ACT, 0, 0);

    // Every expected ack must have been observed
    expect_val(K_DRAIN, 0, 0);
    @(negedge clk_centi_second);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
